sample_capture: RTL

SAMPLE_CAPTURE -- requirements
Module: sample_capture

---
 rtl/capture_pkg.sv | 17 +
 rtl/trigger_detect.sv | 43 ++++
 rtl/sample_capture.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// Shared types and constants for the sample_capture block.
package capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    WAIT_VB,
    PUBLISH
  } state_t;

  // Valid samples tolerated in WAIT_TRIG before a trigger is forced (AUTO_TRIG_EN builds).
  localparam int unsigned AUTO_TRIG_TIMEOUT = 1024;
  localparam int          AUTO_TRIG_W       = $clog2(AUTO_TRIG_TIMEOUT) + 1;

endpackage

// File: rtl/trigger_detect.sv
// Level-crossing trigger detector: remembers the previous accepted sample and
// flags a rising or falling crossing of trig_level on the current one.
module trigger_detect #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_rising,
  output logic              hit
);

  logic [DATA_W-1:0] prev;
  logic              prev_valid;

  // Track the previous accepted sample; a new capture forgets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (clear) begin
      prev_valid <= 1'b0;
    end else if (sample_valid) begin
      // NOTE: registers take <= so every flop samples pre-edge values regardless of statement order.
      prev       <= sample_data;
      prev_valid <= 1'b1;
    end
  end

  // Crossing test between prev and the current sample; needs a real prev.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    hit = 1'b0;
    if (sample_valid && prev_valid) begin
      if (trig_rising) hit = (prev < trig_level) && (sample_data >= trig_level);
      else             hit = (prev > trig_level) && (sample_data <= trig_level);
    end
  end

endmodule

// File: rtl/sample_capture.sv
// Triggered oscilloscope-style capture: samples go into a ring buffer, a level
// trigger freezes a frame with PRETRIG samples of history, and the frame is
// copied to data_display one entry per cycle starting at a vblnk rising edge.
// Optional build macro: AUTO_TRIG_EN forces a trigger after a long trigger-less wait.
module sample_capture
  import capture_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int DATA_W  = 8,
  parameter int PRETRIG = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_rising,
  input  logic              arm,
  input  logic              vblnk,
  output logic [DATA_W-1:0] data_display [DEPTH],
  output logic              busy,
  output logic              capture_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  state_t            state;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  pre_cnt;
  logic [CNT_W-1:0]  post_cnt;
  logic [PTR_W-1:0]  start_ptr;
  logic [CNT_W-1:0]  pub_idx;
  logic              vblnk_q;
  logic [DATA_W-1:0] ring [DEPTH];

  logic accept;
  logic clear_prev;
  logic hit;
  logic trig_fire;

  assign accept     = sample_valid && (state == PRE || state == WAIT_TRIG || state == POST);
  assign clear_prev = (state == IDLE) && arm;

  trigger_detect #(.DATA_W(DATA_W)) u_trig (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear_prev),
    .sample_valid (accept),
    .sample_data  (sample_data),
    .trig_level   (trig_level),
    .trig_rising  (trig_rising),
    .hit          (hit)
  );

`ifdef AUTO_TRIG_EN
  logic [AUTO_TRIG_W-1:0] wait_cnt;

  // Count accepted samples spent waiting; the sample after the timeout fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wait_cnt <= '0;
    else if (state != WAIT_TRIG) wait_cnt <= '0;
    else if (accept)             wait_cnt <= wait_cnt + 1'b1;
  end

  assign trig_fire = accept && (hit || wait_cnt == AUTO_TRIG_W'(AUTO_TRIG_TIMEOUT));
`else
  assign trig_fire = accept && hit;
`endif

  // Ring buffer write port.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays carry no reset; every entry read is written first in a capture.
    if (accept) ring[wr_ptr] <= sample_data;
  end

  // Capture sequencer with registered busy/capture_done and the display copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      pre_cnt      <= '0;
      post_cnt     <= '0;
      start_ptr    <= '0;
      pub_idx      <= '0;
      vblnk_q      <= 1'b0;
      busy         <= 1'b0;
      capture_done <= 1'b0;
      for (int i = 0; i < DEPTH; i++) data_display[i] <= '0;
    end else begin
      capture_done <= 1'b0;
      vblnk_q      <= vblnk;
      if (accept) wr_ptr <= wr_ptr + 1'b1;

      case (state)
        IDLE: begin
          if (arm) begin
            wr_ptr  <= '0;
            pre_cnt <= '0;
            busy    <= 1'b1;
            if (PRETRIG == 0) state <= WAIT_TRIG;
            else              state <= PRE;
          end
        end

        PRE: begin
          if (accept) begin
            pre_cnt <= pre_cnt + 1'b1;
            if (pre_cnt == PTR_W'(PRETRIG - 1)) state <= WAIT_TRIG;
          end
        end

        WAIT_TRIG: begin
          if (trig_fire) begin
            start_ptr <= wr_ptr - PTR_W'(PRETRIG);
            post_cnt  <= CNT_W'(1);
            if (DEPTH - PRETRIG == 1) state <= WAIT_VB;
            else                      state <= POST;
          end
        end

        POST: begin
          if (accept) begin
            post_cnt <= post_cnt + 1'b1;
            if (post_cnt == CNT_W'(DEPTH - PRETRIG - 1)) state <= WAIT_VB;
          end
        end

        WAIT_VB: begin
          if (vblnk && !vblnk_q) begin
            pub_idx <= '0;
            state   <= PUBLISH;
          end
        end

        PUBLISH: begin
          if (!pub_idx[PTR_W]) begin
            data_display[pub_idx[PTR_W-1:0]] <= ring[start_ptr + pub_idx[PTR_W-1:0]];
            pub_idx <= pub_idx + 1'b1;
          end else begin
            capture_done <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
